// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, fetch FSM encoding,
// the default halt encoding and a saturating counter helper.
package instr_fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int WORD_W  = 32;
    localparam int COUNT_W = 16;

    localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        logic [COUNT_W-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Single-stage instruction fetch: PC, BOOT/RUN/HALT control, IF/ID pipeline
// register and a saturating count of loaded instructions.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
    parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic [ADDR_W-1:0]   instr_read_address,
    input  logic [WORD_W-1:0]   instr_instruction,
    output logic                ifid_valid,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [WORD_W-1:0]   ifid_instr,
    output logic                halted,
    output logic [COUNT_W-1:0]  fetch_count
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic [WORD_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic                halted_q, halted_d;
    logic [COUNT_W-1:0]  fetch_count_q, fetch_count_d;

    // Next-state logic: redirect outranks stall, stall outranks the FSM step.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            pc_d         = redirect_target;
            ifid_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else if (stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    ifid_valid_d  = 1'b1;
                    ifid_pc_d     = pc_q;
                    ifid_instr_d  = instr_instruction;
                    fetch_count_d = sat_inc(fetch_count_q);
                    // The halt word is delivered downstream but the PC parks on it.
                    if (instr_instruction == HALT_WORD) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
                ST_HALT: begin
                    ifid_valid_d = 1'b0;
                end
                default: begin
                    state_d      = ST_BOOT;
                    ifid_valid_d = 1'b0;
                end
            endcase
        end

        halted_d = (state_d == ST_HALT);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            ifid_valid_q  <= 1'b0;
            ifid_pc_q     <= 8'h00;
            ifid_instr_q  <= 32'h0000_0000;
            halted_q      <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr_read_address = pc_q;
    assign ifid_valid         = ifid_valid_q;
    assign ifid_pc            = ifid_pc_q;
    assign ifid_instr         = ifid_instr_q;
    assign halted             = halted_q;
    assign fetch_count        = fetch_count_q;

endmodule
